seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Display-side consumer for the per-state message generators (welcome, game, score, error, coin, pass).
- Generates the `refresh` digit index and `ref_sign` fetch strobe that those generators respond to.
- Captures the returned 6-bit character code into a 4-entry digit buffer.
- Time-multiplexes the buffer onto a 4-digit common-anode 7-segment display, with per-digit blinking.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot.
- CAP_LAT, 2, cycles from the `ref_sign` strobe to a valid `msg_in` (matches the generators' two register stages).
- BLANK, 16, cycles at slot start with all anodes off (anti-ghosting). Constraint: CAP_LAT < BLANK < SCAN_DIV.
- BLINK_FRAMES, 64, full 4-digit frames per blink phase toggle.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- en  in  1  1 = fetch/capture enabled; 0 = freeze buffer, keep scanning.
- msg_in  in  6  character code from the selected message generator.
- blink_mask  in  4  bit k = 1 blinks digit k.
- ref_sign  out  1  one-cycle fetch strobe.
- refresh  out  2  digit index currently fetched and displayed (3 = leftmost).
- an  out  4  anodes, active-low; an[k] is digit k.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; held at 1 (off).
- frame_done  out  1  one-cycle pulse at the end of each 4-digit frame.

Behaviour:
- **Reset** (sampled at posedge while rst_n = 0):
  - internal counters: cnt = 0, k = 0, frame_cnt = 0, blink_phase = 0.
  - all four buffer entries = 36 (blank).
  - outputs: ref_sign = 0, refresh = 0, an = 4'b1111, seg = 7'h7F, dp = 1, frame_done = 0.
  - Reset mid-operation discards everything; scanning restarts at digit 0, cnt 0.
- **Slot counter**:
  - cnt runs 0..SCAN_DIV-1 and then wraps.
  - On wrap, k advances k+1 mod 4 (0 → 1 → 2 → 3 → 0).
  - refresh = k, registered, held constant for the whole slot.
- **Fetch strobe**: ref_sign = 1 exactly in the cycle where cnt == 0 and en = 1; otherwise 0.
- **Capture**:
  - When cnt == CAP_LAT and en = 1, buf[k] <= msg_in.
  - No other buffer writes.
  - en = 0 produces no strobes and no captures; the buffer holds and the display keeps its last content.
  - An en change takes effect from the next slot boundary only for the strobe. Capture is gated by en sampled at the capture cycle.
- **Drive** (registered, one cycle after the counter state):
  - an[k] = 0 iff cnt >= BLANK and not (blink_mask[k] & blink_phase). The other three anodes are always 1.
  - seg = decode(buf[k]) while an[k] = 0; otherwise 7'h7F.
- **Decode** (gfedcba, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Letters are coded A = 10 … Z = 35: A = 0001000, C = 1000110, E = 0000110, F = 0001110, H = 0001001, L = 1000111, O = 1000000, P = 0001100, S = 0010010, U = 1000001.
  - Other letters 10..35 = blank (1111111).
  - 36 = blank, 37 = '-' (0111111), 38..63 = blank.
- **Frame and blink**:
  - frame_done = 1 for one cycle when cnt == SCAN_DIV-1 and k == 3.
  - frame_cnt increments on frame_done; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - blink_mask changes apply immediately (combinational into the anode register).
- **Simultaneous events**: reset dominates. A capture in the same cycle as an en fall uses the sampled en = 1.

Test Plan (SCAN_DIV = 8, CAP_LAT = 2, BLANK = 3, BLINK_FRAMES = 2):
1. **Reset values**: hold rst_n = 0 for 3 clocks → an = 1111, seg = 7F, dp = 1, ref_sign = 0, refresh = 0. Then release → ref_sign = 1 with refresh = 0 in the first cycle, and every 8 cycles after; refresh steps 0, 1, 2, 3, 0.
2. **"PASS" fetch**: bench model returns 28, 28, 10, 25 for refresh 0..3 with 2-cycle latency. Second frame, at cnt >= 3 of each slot:
   - slot 3: an = 0111, seg = 0001100.
   - slot 2: an = 1011, seg = 0001000.
   - slots 1 and 0: an = 1101 and 1110, seg = 0010010.
3. **Freeze**: en = 0 from mid-frame, msg_in forced to 0 → ref_sign stays 0 and the display keeps showing PASS. Restore en = 1 → digit shows 1000000 from the next fetch.
4. **Blink**: blink_mask = 1000 → an[3] stays 1 in frames 3–4, 7–8, … (blink_phase = 1) and is active in the other frames. Digits 0–2 are unaffected; frame_done pulses once per 32 cycles.
5. **Decode boundaries**: msg_in = 37, 36, 40, 63 → seg = 0111111, 1111111, 1111111, 1111111; msg_in = 9 → 0010000.
6. **Reset mid-slot**: rst_n = 0 at cnt = 5 of slot 2 → next cycle shows reset values and buffer blank (seg stays 7F on all digits). After release, scanning restarts at refresh = 0 with ref_sign = 1.

Source files
------------

// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - fetch/capture and display signals of the segment scan driver
interface seg_scan_driver_if;
    logic       en;
    logic [5:0] msg_in;
    logic [3:0] blink_mask;
    logic       ref_sign;
    logic [1:0] refresh;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    modport master (
        input  en, msg_in, blink_mask,
        output ref_sign, refresh, an, seg, dp, frame_done
    );

    modport slave (
        output en, msg_in, blink_mask,
        input  ref_sign, refresh, an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 4-digit multiplexed 7-segment driver with fetch strobe, digit buffer and blink
module seg_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int CAP_LAT      = 2,
    parameter int BLANK        = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_driver_if.master  bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    k_q, k_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [5:0]    digit_buf_q [4];
    logic [5:0]    digit_buf_d [4];
    logic          ref_sign_q, ref_sign_d;
    logic [1:0]    refresh_q, refresh_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_done_q, frame_done_d;
    logic          slot_end, frame_end, digit_on;

    function automatic logic [6:0] decode(input logic [5:0] code);
        case (code)
            6'd0:    decode = 7'b1000000;
            6'd1:    decode = 7'b1111001;
            6'd2:    decode = 7'b0100100;
            6'd3:    decode = 7'b0110000;
            6'd4:    decode = 7'b0011001;
            6'd5:    decode = 7'b0010010;
            6'd6:    decode = 7'b0000010;
            6'd7:    decode = 7'b1111000;
            6'd8:    decode = 7'b0000000;
            6'd9:    decode = 7'b0010000;
            6'd10:   decode = 7'b0001000;   // A
            6'd12:   decode = 7'b1000110;   // C
            6'd14:   decode = 7'b0000110;   // E
            6'd15:   decode = 7'b0001110;   // F
            6'd17:   decode = 7'b0001001;   // H
            6'd21:   decode = 7'b1000111;   // L
            6'd24:   decode = 7'b1000000;   // O
            6'd25:   decode = 7'b0001100;   // P
            6'd28:   decode = 7'b0010010;   // S
            6'd30:   decode = 7'b1000001;   // U
            6'd37:   decode = 7'b0111111;   // '-'
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        slot_end  = (cnt_q == CW'(SCAN_DIV - 1));
        frame_end = slot_end && (k_q == 2'd3);
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        k_d       = slot_end ? k_q + 2'd1 : k_q;

        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_end) begin
            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        // msg_in is valid CAP_LAT cycles after the strobe issued at cnt 0
        digit_buf_d = digit_buf_q;
        if ((cnt_q == CW'(CAP_LAT)) && bus.en) begin
            digit_buf_d[k_q] = bus.msg_in;
        end

        ref_sign_d   = (cnt_q == '0) && bus.en;
        refresh_d    = k_q;
        frame_done_d = frame_end;

        // anodes stay dark for the first BLANK cycles of every slot to avoid ghosting
        digit_on = (cnt_q >= CW'(BLANK)) && !(bus.blink_mask[k_q] && blink_phase_q);
        an_d     = 4'b1111;
        seg_d    = 7'h7F;
        if (digit_on) begin
            an_d[k_q] = 1'b0;
            seg_d     = decode(digit_buf_q[k_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            k_q           <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            digit_buf_q   <= '{default: 6'd36};
            ref_sign_q    <= 1'b0;
            refresh_q     <= 2'd0;
            an_q          <= 4'b1111;
            seg_q         <= 7'h7F;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            k_q           <= k_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            digit_buf_q   <= digit_buf_d;
            ref_sign_q    <= ref_sign_d;
            refresh_q     <= refresh_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bus.ref_sign   = ref_sign_q;
    assign bus.refresh    = refresh_q;
    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.frame_done = frame_done_q;
endmodule
